axil_irq_sink: RTL and testbench
================================

Name: axil_irq_sink

Overview:
- AXI4-Lite slave that terminates the interrupt-notification writes issued by the PLIC wrapper's IRQ-to-AXI-lite master.
- Holds one level register per interrupt target and drives it as irq_o[i] into the core's external-interrupt inputs (meip/seip).
- Registers are readable back over the same port for polling and debug.
- Unmapped accesses get an error response and change no state.

Parameters:
- axil_data_width_p, 32, AXI-lite data width; must be 32.
- axil_addr_width_p, 32, AXI-lite address width.
- num_targets_p, 2, number of interrupt targets (0 = M-mode, 1 = S-mode).
- base_addr_p, 'h30_b000, byte address of target 0's register.
- target_stride_p, 4, byte spacing between target registers; power of two, at least 4.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- s_axil_awaddr_i  in  axil_addr_width_p  write address
- s_axil_awprot_i  in  3  ignored
- s_axil_awvalid_i  in  1  AW valid
- s_axil_awready_o  out  1  AW ready
- s_axil_wdata_i  in  axil_data_width_p  write data
- s_axil_wstrb_i  in  axil_data_width_p/8  byte strobes
- s_axil_wvalid_i  in  1  W valid
- s_axil_wready_o  out  1  W ready
- s_axil_bresp_o  out  2  write response
- s_axil_bvalid_o  out  1  B valid
- s_axil_bready_i  in  1  B ready
- s_axil_araddr_i  in  axil_addr_width_p  read address
- s_axil_arprot_i  in  3  ignored
- s_axil_arvalid_i  in  1  AR valid
- s_axil_arready_o  out  1  AR ready
- s_axil_rdata_o  out  axil_data_width_p  read data
- s_axil_rresp_o  out  2  read response
- s_axil_rvalid_o  out  1  R valid
- s_axil_rready_i  in  1  R ready
- irq_o  out  num_targets_p  registered interrupt level per target

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset values: irq_o=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, AW and W holding slots empty. awready and wready are 1 in the first cycle after reset; arready=1.
- Reset mid-transaction drops any held AW/W and any pending B or R; no response is ever issued for it.
- Address decode:
  - offset = addr - base_addr_p.
  - Hit when addr >= base_addr_p, offset % target_stride_p == 0, and offset/target_stride_p < num_targets_p.
  - Otherwise the access is a miss.
- Write path states (derived from two holding slots plus bvalid): IDLE, HAVE_AW, HAVE_W, RESP.
  - awready = AW slot empty & ~bvalid.
  - wready = W slot empty & ~bvalid.
  - AW and W may arrive in either order or in the same cycle.
  - Commit occurs in the cycle both slots are full (registered). The same cycle sets bvalid=1 and clears both slots. bvalid is visible at most 1 cycle after the later of the AW/W handshakes.
  - Commit on a hit: if wstrb[0]=1, irq_o[idx] <= wdata[0], visible the cycle after commit; bresp=OKAY(00). If wstrb[0]=0, no change and bresp=OKAY.
  - Commit on a miss: no state change; bresp=DECERR(11).
  - RESP holds bvalid and bresp until bready is high; the handshake cycle clears bvalid. The next AW/W is accepted no earlier than the following cycle.
  - Only one outstanding write at a time.
- Read path states: IDLE, RESP.
  - arready = ~rvalid.
  - The AR handshake registers rvalid=1 next cycle.
  - Hit: rdata={zeros, irq_o[idx]} sampled in the AR handshake cycle; rresp=OKAY.
  - Miss: rdata=0, rresp=DECERR.
  - rvalid, rdata and rresp are held stable until rready; they clear on the handshake cycle.
- Read/write same cycle:
  - Independent paths.
  - A read handshaking in the same cycle as a write commit to the same target returns the pre-write value.
- Back-to-back writes with identical data leave irq_o unchanged (level semantics; no glitch).
- Simulation-only check: error if axil_data_width_p != 32 or target_stride_p < 4.

Decomposition:
- Package axil_irq_sink_pkg:
  - AXI response constants (e_axi_resp_okay=2'b00, e_axi_resp_slverr=2'b10, e_axi_resp_decerr=2'b11).
  - An address-decode result struct {hit, idx}.
- One natural sub-module, axil_irq_sink_decode: combinational address-to-{hit, idx} decoder. It is instantiated twice, once for the AW slot and once for AR.
- Holding slots use bsg_dff_en/bsg_dff_reset_set_clear.

Test Plan:
- Write-then-read, AW and W same cycle: write addr 'h30_b004, data 1, wstrb 'hF -> bvalid within 1 cycle with bresp=00, irq_o=2'b10; read 'h30_b004 -> rdata=1, rresp=00.
- W before AW by 3 cycles: W with data 1, then AW 'h30_b000 -> wready low while the W slot is held; bvalid within 1 cycle of the AW handshake; irq_o[0]=1. A later data-0 write -> irq_o[0]=0.
- Miss: write 'h30_b008 and read 'h30_b002 (num_targets_p=2) -> bresp=11, rresp=11, rdata=0, irq_o unchanged.
- Backpressure: hold bready=0 for 5 cycles -> bvalid and bresp stable, awready=0, wready=0; a second queued AW is accepted only after the B handshake. Same for rready=0 with arready=0.
- Strobe/race: wstrb=0 with data 1 -> irq_o unchanged, bresp=00. Read of target 1 in the same cycle as a commit writing 1 -> returns 0; the next read returns 1.
- Reset mid-transaction: AW accepted, W pending, then reset_i high for 1 cycle -> no bvalid ever, irq_o=0, awready=1 and wready=1 next cycle.

Source files
------------

// File: rtl/axil_irq_sink_pkg.sv
// Shared types for the AXI-lite interrupt sink: response codes, decode result, path states.
package axil_irq_sink_pkg;

    typedef enum logic [1:0] {
        e_axi_resp_okay   = 2'b00,
        e_axi_resp_exokay = 2'b01,
        e_axi_resp_slverr = 2'b10,
        e_axi_resp_decerr = 2'b11
    } axi_resp_e;

    // Wide enough for up to 256 targets; the decoder range-checks before indexing.
    localparam int irq_idx_width_lp = 8;
    typedef logic [irq_idx_width_lp-1:0] irq_idx_t;

    typedef struct packed {
        logic     hit;
        irq_idx_t idx;
    } decode_s;

    typedef enum logic [1:0] {
        e_wr_idle,
        e_wr_have_aw,
        e_wr_have_w,
        e_wr_resp
    } wr_state_e;

    typedef enum logic {
        e_rd_idle,
        e_rd_resp
    } rd_state_e;

endpackage

// File: rtl/axil_irq_sink_decode.sv
// Combinational address decode: maps a byte address onto a target register index.
module axil_irq_sink_decode
    import axil_irq_sink_pkg::*;
#(
    parameter int                           axil_addr_width_p = 32,
    parameter int                           num_targets_p     = 2,
    parameter logic [axil_addr_width_p-1:0] base_addr_p       = 'h30_b000,
    parameter int                           target_stride_p   = 4
) (
    input  logic [axil_addr_width_p-1:0] addr_i,
    output decode_s                      decode_o
);

    localparam int stride_shift_lp = $clog2(target_stride_p);

    logic [axil_addr_width_p-1:0] offset;
    logic [axil_addr_width_p-1:0] slot_num;

    assign offset   = addr_i - base_addr_p;
    assign slot_num = offset >> stride_shift_lp;

    // Range check uses the full slot number so wrapped or far-away addresses never alias a target.
    always_comb begin
        decode_o.hit = (addr_i >= base_addr_p)
                    && (offset[stride_shift_lp-1:0] == '0)
                    && (slot_num < axil_addr_width_p'(num_targets_p));
        decode_o.idx = slot_num[irq_idx_width_lp-1:0];
    end

endmodule

// File: rtl/bsg_dff_en.sv
// Enable-gated register without reset; used for payloads whose validity is tracked elsewhere.
module bsg_dff_en #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_r;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            data_r <= data_i;
        end
    end

    assign data_o = data_r;

endmodule

// File: rtl/bsg_dff_reset_set_clear.sv
// Set/clear flag register with synchronous active-high reset.
module bsg_dff_reset_set_clear #(
    parameter int width_p          = 1,
    parameter bit clear_over_set_p = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] set_i,
    input  logic [width_p-1:0] clear_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_r <= '0;
        end else if (clear_over_set_p) begin
            data_r <= (data_r | set_i) & ~clear_i;
        end else begin
            data_r <= (data_r & ~clear_i) | set_i;
        end
    end

    assign data_o = data_r;

endmodule

// File: rtl/axil_irq_sink.sv
// AXI4-Lite slave terminating interrupt-notification writes; one level register per target drives irq_o.
//
// write state  | meaning
// e_wr_idle    | both holding slots empty, no response pending
// e_wr_have_aw | address held, waiting for write data
// e_wr_have_w  | write data held, waiting for address
// e_wr_resp    | commit this cycle, or B response waiting for bready
//
// read state   | meaning
// e_rd_idle    | ready to accept AR
// e_rd_resp    | R response held until rready
module axil_irq_sink
    import axil_irq_sink_pkg::*;
#(
    parameter int                           axil_data_width_p = 32,
    parameter int                           axil_addr_width_p = 32,
    parameter int                           num_targets_p     = 2,
    parameter logic [axil_addr_width_p-1:0] base_addr_p       = 'h30_b000,
    parameter int                           target_stride_p   = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,

    input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
    input  logic [2:0]                     s_axil_awprot_i,
    input  logic                           s_axil_awvalid_i,
    output logic                           s_axil_awready_o,

    input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
    input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
    input  logic                           s_axil_wvalid_i,
    output logic                           s_axil_wready_o,

    output logic [1:0]                     s_axil_bresp_o,
    output logic                           s_axil_bvalid_o,
    input  logic                           s_axil_bready_i,

    input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
    input  logic [2:0]                     s_axil_arprot_i,
    input  logic                           s_axil_arvalid_i,
    output logic                           s_axil_arready_o,

    output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
    output logic [1:0]                     s_axil_rresp_o,
    output logic                           s_axil_rvalid_o,
    input  logic                           s_axil_rready_i,

    output logic [num_targets_p-1:0]       irq_o
);

    if (axil_data_width_p != 32) begin : g_bad_data_width
        $error("axil_irq_sink: axil_data_width_p must be 32");
    end
    if (target_stride_p < 4 || (target_stride_p & (target_stride_p - 1)) != 0) begin : g_bad_stride
        $error("axil_irq_sink: target_stride_p must be a power of two of at least 4");
    end
    if (num_targets_p < 1 || num_targets_p > (1 << irq_idx_width_lp)) begin : g_bad_targets
        $error("axil_irq_sink: num_targets_p out of range");
    end

    logic                          aw_full;
    logic                          w_full;
    logic [axil_addr_width_p-1:0]  aw_addr_r;
    logic [1:0]                    w_held;   // {wstrb[0], wdata[0]}

    logic                          bvalid_r;
    logic [1:0]                    bresp_r;
    logic                          rvalid_r;
    logic [1:0]                    rresp_r;
    logic [axil_data_width_p-1:0]  rdata_r;
    logic [num_targets_p-1:0]      irq_r;
    logic [num_targets_p-1:0]      irq_n;
    logic                          rd_bit;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;

    wr_state_e wr_state;
    rd_state_e rd_state;
    decode_s   aw_dec;
    decode_s   ar_dec;

    always_comb begin
        wr_state = e_wr_idle;
        if (bvalid_r || (aw_full && w_full)) begin
            wr_state = e_wr_resp;
        end else if (aw_full) begin
            wr_state = e_wr_have_aw;
        end else if (w_full) begin
            wr_state = e_wr_have_w;
        end
    end

    assign rd_state = rvalid_r ? e_rd_resp : e_rd_idle;

    assign s_axil_awready_o = (wr_state == e_wr_idle) || (wr_state == e_wr_have_w);
    assign s_axil_wready_o  = (wr_state == e_wr_idle) || (wr_state == e_wr_have_aw);
    assign s_axil_arready_o = (rd_state == e_rd_idle);

    assign aw_hs  = s_axil_awvalid_i & s_axil_awready_o;
    assign w_hs   = s_axil_wvalid_i & s_axil_wready_o;
    assign b_hs   = bvalid_r & s_axil_bready_i;
    assign ar_hs  = s_axil_arvalid_i & s_axil_arready_o;
    assign r_hs   = rvalid_r & s_axil_rready_i;
    assign commit = aw_full & w_full;

    bsg_dff_reset_set_clear #(.width_p(1)) aw_full_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .set_i   (aw_hs),
        .clear_i (commit),
        .data_o  (aw_full)
    );

    bsg_dff_reset_set_clear #(.width_p(1)) w_full_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .set_i   (w_hs),
        .clear_i (commit),
        .data_o  (w_full)
    );

    bsg_dff_en #(.width_p(axil_addr_width_p)) aw_addr_reg (
        .clk_i  (clk_i),
        .en_i   (aw_hs),
        .data_i (s_axil_awaddr_i),
        .data_o (aw_addr_r)
    );

    bsg_dff_en #(.width_p(2)) w_data_reg (
        .clk_i  (clk_i),
        .en_i   (w_hs),
        .data_i ({s_axil_wstrb_i[0], s_axil_wdata_i[0]}),
        .data_o (w_held)
    );

    axil_irq_sink_decode #(
        .axil_addr_width_p (axil_addr_width_p),
        .num_targets_p     (num_targets_p),
        .base_addr_p       (base_addr_p),
        .target_stride_p   (target_stride_p)
    ) aw_decode (
        .addr_i   (aw_addr_r),
        .decode_o (aw_dec)
    );

    axil_irq_sink_decode #(
        .axil_addr_width_p (axil_addr_width_p),
        .num_targets_p     (num_targets_p),
        .base_addr_p       (base_addr_p),
        .target_stride_p   (target_stride_p)
    ) ar_decode (
        .addr_i   (s_axil_araddr_i),
        .decode_o (ar_dec)
    );

    always_comb begin
        irq_n = irq_r;
        if (commit && aw_dec.hit && w_held[1]) begin
            for (int i = 0; i < num_targets_p; i++) begin
                if (aw_dec.idx == irq_idx_t'(i)) begin
                    irq_n[i] = w_held[0];
                end
            end
        end
    end

    // Read mux looks at irq_r, so a read racing a commit returns the pre-write level.
    always_comb begin
        rd_bit = 1'b0;
        for (int i = 0; i < num_targets_p; i++) begin
            if (ar_dec.idx == irq_idx_t'(i)) begin
                rd_bit = irq_r[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bvalid_r <= 1'b0;
            bresp_r  <= e_axi_resp_okay;
            rvalid_r <= 1'b0;
            rresp_r  <= e_axi_resp_okay;
            rdata_r  <= '0;
            irq_r    <= '0;
        end else begin
            irq_r <= irq_n;

            if (commit) begin
                bvalid_r <= 1'b1;
                bresp_r  <= aw_dec.hit ? e_axi_resp_okay : e_axi_resp_decerr;
            end else if (b_hs) begin
                bvalid_r <= 1'b0;
                bresp_r  <= e_axi_resp_okay;
            end

            if (ar_hs) begin
                rvalid_r <= 1'b1;
                rresp_r  <= ar_dec.hit ? e_axi_resp_okay : e_axi_resp_decerr;
                rdata_r  <= axil_data_width_p'(ar_dec.hit & rd_bit);
            end else if (r_hs) begin
                rvalid_r <= 1'b0;
                rresp_r  <= e_axi_resp_okay;
                rdata_r  <= '0;
            end
        end
    end

    assign s_axil_bvalid_o = bvalid_r;
    assign s_axil_bresp_o  = bresp_r;
    assign s_axil_rvalid_o = rvalid_r;
    assign s_axil_rresp_o  = rresp_r;
    assign s_axil_rdata_o  = rdata_r;
    assign irq_o           = irq_r;

    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awprot_i, s_axil_arprot_i,
                             s_axil_wdata_i[axil_data_width_p-1:1],
                             s_axil_wstrb_i[axil_data_width_p/8-1:1]};

endmodule

// File: tb/tb_axil_irq_sink.sv
// Self-checking bench for axil_irq_sink: directed scenarios plus randomized traffic against an address-rule model.
module tb_axil_irq_sink;

    localparam int          NT   = 2;
    localparam logic [31:0] BASE = 32'h30_b000;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [NT-1:0] irq;

    int checks = 0;
    int errors = 0;
    logic [NT-1:0] model_irq;

    always #5 clk_i = ~clk_i;

    axil_irq_sink dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .s_axil_awaddr_i  (awaddr),
        .s_axil_awprot_i  (awprot),
        .s_axil_awvalid_i (awvalid),
        .s_axil_awready_o (awready),
        .s_axil_wdata_i   (wdata),
        .s_axil_wstrb_i   (wstrb),
        .s_axil_wvalid_i  (wvalid),
        .s_axil_wready_o  (wready),
        .s_axil_bresp_o   (bresp),
        .s_axil_bvalid_o  (bvalid),
        .s_axil_bready_i  (bready),
        .s_axil_araddr_i  (araddr),
        .s_axil_arprot_i  (arprot),
        .s_axil_arvalid_i (arvalid),
        .s_axil_arready_o (arready),
        .s_axil_rdata_o   (rdata),
        .s_axil_rresp_o   (rresp),
        .s_axil_rvalid_o  (rvalid),
        .s_axil_rready_i  (rready),
        .irq_o            (irq)
    );

    // Reference decode straight from the address rule.
    function automatic bit model_hit(input logic [31:0] a);
        longint unsigned off;
        if (a < BASE) return 1'b0;
        off = longint'(a) - longint'(BASE);
        return (off % 4 == 0) && (off / 4 < NT);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return model_hit(a) ? 2'b00 : 2'b11;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic d, input logic [3:0] s);
        if (model_hit(a) && s[0]) model_irq[model_idx(a)] = d;
    endtask

    task automatic send_aw(input logic [31:0] a);
        bit done = 1'b0;
        awaddr  = a;
        awvalid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (awready) begin
                done = 1'b1;
                @(negedge clk_i);
                break;
            end
            @(negedge clk_i);
        end
        awvalid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL aw_timeout: awready never high, required within 40 cycles");
        end
    endtask

    task automatic send_w(input logic d, input logic [3:0] s);
        bit done = 1'b0;
        wdata  = ($urandom() & 32'hFFFF_FFFE) | {31'd0, d};
        wstrb  = s;
        wvalid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (wready) begin
                done = 1'b1;
                @(negedge clk_i);
                break;
            end
            @(negedge clk_i);
        end
        wvalid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL w_timeout: wready never high, required within 40 cycles");
        end
    endtask

    task automatic wait_b(output logic [1:0] resp, output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            if (bvalid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_i);
            lat++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL b_timeout: bvalid never high, required within 40 cycles");
        end
        resp   = bresp;
        bready = 1'b1;
        @(negedge clk_i);
        bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic d, input logic [3:0] s,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output int lat);
        fork
            begin repeat (aw_dly) @(negedge clk_i); send_aw(a); end
            begin repeat (w_dly) @(negedge clk_i); send_w(d, s); end
        join
        wait_b(resp, lat);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        bit done = 1'b0;
        araddr  = a;
        arvalid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (arready) begin
                done = 1'b1;
                @(negedge clk_i);
                break;
            end
            @(negedge clk_i);
        end
        arvalid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL ar_timeout: arready never high, required within 40 cycles");
        end
        lat  = 0;
        done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (rvalid) begin
                done = 1'b1;
                break;
            end
            @(negedge clk_i);
            lat++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL r_timeout: rvalid never high, required within 40 cycles");
        end
        data   = rdata;
        resp   = rresp;
        rready = 1'b1;
        @(negedge clk_i);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (irq !== 2'b00) begin errors++; $display("FAIL reset_irq: got %b, expected 00", irq); end
        checks++;
        if ({bvalid, rvalid} !== 2'b00) begin errors++; $display("FAIL reset_valids: got bvalid=%b rvalid=%b, expected 0 0", bvalid, rvalid); end
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++; $display("FAIL reset_readies: got aw=%b w=%b ar=%b, expected 1 1 1", awready, wready, arready);
        end
        checks++;
        if ({bresp, rresp} !== 4'b0000 || rdata !== 32'd0) begin
            errors++; $display("FAIL reset_resp: got bresp=%b rresp=%b rdata=%h, expected 00 00 0", bresp, rresp, rdata);
        end
    endtask

    task automatic test_write_read_same_cycle();
        logic [1:0] resp; logic [31:0] d; int lat;
        do_write(BASE + 4, 1'b1, 4'hF, 0, 0, resp, lat);
        model_write(BASE + 4, 1'b1, 4'hF);
        checks++;
        if (resp !== 2'b00 || lat > 1) begin errors++; $display("FAIL wr_same_bresp: got resp=%b lat=%0d, expected 00 lat<=1", resp, lat); end
        checks++;
        if (irq !== model_irq) begin errors++; $display("FAIL wr_same_irq: got %b, expected %b", irq, model_irq); end
        do_read(BASE + 4, d, resp, lat);
        checks++;
        if (d !== 32'd1 || resp !== 2'b00 || lat != 0) begin
            errors++; $display("FAIL rd_same: got rdata=%h rresp=%b lat=%0d, expected 1 00 0", d, resp, lat);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; int lat;
        send_w(1'b1, 4'hF);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (wready !== 1'b0 || awready !== 1'b1) begin
                errors++; $display("FAIL w_held_ready: got wready=%b awready=%b, expected 0 1", wready, awready);
            end
            @(negedge clk_i);
        end
        send_aw(BASE);
        wait_b(resp, lat);
        model_write(BASE, 1'b1, 4'hF);
        checks++;
        if (resp !== 2'b00 || lat > 1) begin errors++; $display("FAIL w_first_bresp: got resp=%b lat=%0d, expected 00 lat<=1", resp, lat); end
        checks++;
        if (irq !== model_irq) begin errors++; $display("FAIL w_first_irq: got %b, expected %b", irq, model_irq); end
        do_write(BASE, 1'b0, 4'hF, 0, 0, resp, lat);
        model_write(BASE, 1'b0, 4'hF);
        checks++;
        if (irq !== model_irq || resp !== 2'b00) begin
            errors++; $display("FAIL clear_irq0: got irq=%b resp=%b, expected %b 00", irq, resp, model_irq);
        end
    endtask

    task automatic test_miss();
        logic [1:0] resp; logic [31:0] d; int lat;
        do_write(BASE + 8, 1'b1, 4'hF, 1, 0, resp, lat);
        checks++;
        if (resp !== 2'b11 || irq !== model_irq) begin
            errors++; $display("FAIL miss_write: got resp=%b irq=%b, expected 11 %b", resp, irq, model_irq);
        end
        do_read(BASE + 2, d, resp, lat);
        checks++;
        if (resp !== 2'b11 || d !== 32'd0) begin errors++; $display("FAIL miss_read: got rresp=%b rdata=%h, expected 11 0", resp, d); end
        do_read(BASE - 4, d, resp, lat);
        checks++;
        if (resp !== 2'b11 || d !== 32'd0) begin errors++; $display("FAIL miss_below: got rresp=%b rdata=%h, expected 11 0", resp, d); end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp, resp0; logic [31:0] d, d0; int lat;
        fork
            send_aw(BASE);
            send_w(1'b1, 4'hF);
        join
        model_write(BASE, 1'b1, 4'hF);
        @(negedge clk_i);
        resp0   = bresp;
        awaddr  = BASE + 4;
        awvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
                errors++; $display("FAIL b_stall: got bvalid=%b bresp=%b awready=%b wready=%b, expected 1 00 0 0", bvalid, bresp, awready, wready);
            end
            @(negedge clk_i);
        end
        bready = 1'b1;
        @(negedge clk_i);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || resp0 !== 2'b00) begin
            errors++; $display("FAIL b_release: got bvalid=%b awready=%b resp=%b, expected 0 1 00", bvalid, awready, resp0);
        end
        fork
            send_aw(BASE + 4);
            send_w(1'b0, 4'hF);
        join
        wait_b(resp, lat);
        model_write(BASE + 4, 1'b0, 4'hF);
        checks++;
        if (resp !== 2'b00 || irq !== model_irq) begin
            errors++; $display("FAIL queued_aw: got resp=%b irq=%b, expected 00 %b", resp, irq, model_irq);
        end

        araddr  = BASE;
        arvalid = 1'b1;
        @(negedge clk_i);
        araddr = BASE + 4;
        d0     = rdata;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== d0 || d0 !== 32'd1 || arready !== 1'b0) begin
                errors++; $display("FAIL r_stall: got rvalid=%b rdata=%h arready=%b, expected 1 1 0", rvalid, rdata, arready);
            end
            @(negedge clk_i);
        end
        rready = 1'b1;
        @(negedge clk_i);
        rready  = 1'b0;
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++; $display("FAIL r_release: got rvalid=%b arready=%b, expected 0 1", rvalid, arready);
        end
        do_read(BASE + 4, d, resp, lat);
        checks++;
        if (d !== {31'd0, model_irq[1]} || resp !== 2'b00) begin
            errors++; $display("FAIL queued_ar: got rdata=%h rresp=%b, expected %0d 00", d, resp, model_irq[1]);
        end
    endtask

    task automatic test_strobe_race();
        logic [1:0] resp; logic [31:0] d; int lat;
        do_write(BASE + 4, 1'b0, 4'hF, 0, 2, resp, lat);
        model_write(BASE + 4, 1'b0, 4'hF);
        do_write(BASE + 4, 1'b1, 4'hE, 0, 0, resp, lat);
        model_write(BASE + 4, 1'b1, 4'hE);
        checks++;
        if (resp !== 2'b00 || irq !== model_irq) begin
            errors++; $display("FAIL strobe0: got resp=%b irq=%b, expected 00 %b", resp, irq, model_irq);
        end

        awaddr = BASE + 4; awvalid = 1'b1;
        wdata  = 32'd1;    wstrb   = 4'hF; wvalid = 1'b1;
        checks++;
        if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL race_ready: got aw=%b w=%b, expected 1 1", awready, wready); end
        @(negedge clk_i);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr  = BASE + 4; arvalid = 1'b1;
        @(negedge clk_i);
        arvalid = 1'b0;
        model_write(BASE + 4, 1'b1, 4'hF);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'd0 || bvalid !== 1'b1) begin
            errors++; $display("FAIL race_read: got rvalid=%b rdata=%h bvalid=%b, expected 1 0 1", rvalid, rdata, bvalid);
        end
        checks++;
        if (irq !== model_irq) begin errors++; $display("FAIL race_irq: got %b, expected %b", irq, model_irq); end
        rready = 1'b1; bready = 1'b1;
        @(negedge clk_i);
        rready = 1'b0; bready = 1'b0;
        do_read(BASE + 4, d, resp, lat);
        checks++;
        if (d !== 32'd1 || resp !== 2'b00) begin errors++; $display("FAIL race_reread: got rdata=%h rresp=%b, expected 1 00", d, resp); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp; int lat; int glitches = 0; bit done = 1'b0;
        do_write(BASE, 1'b1, 4'hF, 0, 0, resp, lat);
        model_write(BASE, 1'b1, 4'hF);
        fork
            begin do_write(BASE, 1'b1, 4'hF, 0, 0, resp, lat); done = 1'b1; end
            begin
                while (!done) begin
                    if (irq !== model_irq) glitches++;
                    @(negedge clk_i);
                end
            end
        join
        checks++;
        if (glitches != 0 || irq !== model_irq) begin
            errors++; $display("FAIL b2b_glitch: got %0d glitch cycles irq=%b, expected 0 %b", glitches, irq, model_irq);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; int lat; int seen = 0;
        do_write(BASE + 4, 1'b1, 4'hF, 0, 0, resp, lat);
        send_aw(BASE);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i   = 1'b0;
        model_irq = '0;
        checks++;
        if (irq !== model_irq || awready !== 1'b1 || wready !== 1'b1) begin
            errors++; $display("FAIL reset_mid: got irq=%b awready=%b wready=%b, expected 00 1 1", irq, awready, wready);
        end
        for (int c = 0; c < 6; c++) begin
            if (bvalid) seen++;
            @(negedge clk_i);
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_mid_b: got %0d bvalid cycles, expected 0", seen); end
    endtask

    task automatic test_random();
        logic [31:0] addrs [8];
        logic [31:0] a, d;
        logic [1:0]  resp;
        logic [3:0]  s;
        logic        bit_d;
        int          lat;
        addrs = '{BASE, BASE + 4, BASE + 8, BASE + 1, BASE + 2, BASE + 6, BASE - 4, 32'h0};
        for (int n = 0; n < 40; n++) begin
            a = addrs[$urandom_range(7)];
            if ($urandom_range(1) == 1) begin
                bit_d = 1'($urandom_range(1));
                s     = 4'($urandom_range(15));
                do_write(a, bit_d, s, $urandom_range(3), $urandom_range(3), resp, lat);
                model_write(a, bit_d, s);
                checks++;
                if (resp !== model_resp(a) || lat > 1 || irq !== model_irq) begin
                    errors++; $display("FAIL rand_write addr=%h: got resp=%b lat=%0d irq=%b, expected %b lat<=1 %b",
                                       a, resp, lat, irq, model_resp(a), model_irq);
                end
            end else begin
                do_read(a, d, resp, lat);
                checks++;
                if (resp !== model_resp(a) || d !== (model_hit(a) ? {31'd0, model_irq[model_idx(a)]} : 32'd0)) begin
                    errors++; $display("FAIL rand_read addr=%h: got rdata=%h rresp=%b, expected resp %b", a, d, resp, model_resp(a));
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        model_irq = '0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;

        test_reset();
        test_write_read_same_cycle();
        test_w_before_aw();
        test_miss();
        test_backpressure();
        test_strobe_race();
        test_back_to_back();
        test_reset_mid();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
